// File: rtl/run_det_pkg.sv
// Shared constants, types and width helper for the run-length detector.
package run_det_pkg;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // run_cur must hold 0..run_len inclusive.
  function automatic int unsigned run_cur_width(input int unsigned run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// Sample inputs and hit/event outputs of run_detector, grouped as one bus.
interface run_detector_if #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  import run_det_pkg::*;

  localparam int unsigned CurW = run_cur_width(RUN_LEN);

  logic             w;
  logic             en;
  logic             mode;
  logic             clr;
  logic             one_yes;
  logic             zero_yes;
  logic [CurW-1:0]  run_cur;
  logic [CNT_W-1:0] ones_events;
  logic [CNT_W-1:0] zeros_events;

  modport master (
    output w, en, mode, clr,
    input  one_yes, zero_yes, run_cur, ones_events, zeros_events
  );

  modport slave (
    input  w, en, mode, clr,
    output one_yes, zero_yes, run_cur, ones_events, zeros_events
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Clear wins over a coincident increment.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/run_detector.sv
// Run-length detector on a serial bit: level or non-overlapping pulse hits,
// gated sampling and saturating per-polarity event counters.
module run_detector import run_det_pkg::*; #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic           clock,
  input logic           resetn,
  run_detector_if.slave bus_io
);

  localparam int unsigned     CurW    = run_cur_width(RUN_LEN);
  localparam logic [CurW-1:0] RunLenC = CurW'(RUN_LEN);
  localparam logic [CurW-1:0] OneC    = CurW'(1);

  state_e          state_q, state_d;
  logic            prev_q, prev_d;
  logic [CurW-1:0] cnt_q, cnt_d;
  logic            one_q, one_d;
  logic            zero_q, zero_d;
  logic            hit;
  logic            hold;
  logic [CNT_W-1:0] ones_cnt, zeros_cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      one_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      one_q   <= one_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    one_d   = one_q;
    zero_d  = zero_q;
    hit     = 1'b0;
    hold    = 1'b0;
    if (bus_io.en) begin
      if ((state_q == StIdle) || (bus_io.w != prev_q)) begin
        state_d = StRun;
        prev_d  = bus_io.w;
        cnt_d   = OneC;
      end else if (cnt_q < RunLenC) begin
        cnt_d = cnt_q + OneC;
      end else if (bus_io.mode == MODE_PULSE) begin
        cnt_d = OneC;
      end else begin
        // Saturated level-mode run continuing: already counted, no new hit.
        hold = 1'b1;
      end
      hit = (cnt_d == RunLenC) && !hold;
      if (bus_io.mode == MODE_LEVEL) begin
        one_d  = (cnt_d == RunLenC) && bus_io.w;
        zero_d = (cnt_d == RunLenC) && !bus_io.w;
      end else begin
        one_d  = hit && bus_io.w;
        zero_d = hit && !bus_io.w;
      end
    end else if (bus_io.mode == MODE_PULSE) begin
      one_d  = 1'b0;
      zero_d = 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_ones_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr    (bus_io.clr),
    .inc    (hit && bus_io.w),
    .q      (ones_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_zeros_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr    (bus_io.clr),
    .inc    (hit && !bus_io.w),
    .q      (zeros_cnt)
  );

  assign bus_io.one_yes      = one_q;
  assign bus_io.zero_yes     = zero_q;
  assign bus_io.run_cur      = cnt_q;
  assign bus_io.ones_events  = ones_cnt;
  assign bus_io.zeros_events = zeros_cnt;

endmodule

// File: tb/tb_run_detector.sv
// Drives three run_detector configurations with shared stimulus and checks them
// against a behavioural model plus directed expectations.
module tb_run_detector;

  logic clock;
  logic resetn;
  logic w_r, en_r, mode_r, clr_r;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Configs: a = RUN_LEN 4 / CNT_W 8, b = RUN_LEN 4 / CNT_W 2, c = RUN_LEN 1 / CNT_W 8.
  run_detector_if #(.RUN_LEN(4), .CNT_W(8)) if_a ();
  run_detector_if #(.RUN_LEN(4), .CNT_W(2)) if_b ();
  run_detector_if #(.RUN_LEN(1), .CNT_W(8)) if_c ();

  run_detector #(.RUN_LEN(4), .CNT_W(8)) dut_a (.clock(clock), .resetn(resetn), .bus_io(if_a));
  run_detector #(.RUN_LEN(4), .CNT_W(2)) dut_b (.clock(clock), .resetn(resetn), .bus_io(if_b));
  run_detector #(.RUN_LEN(1), .CNT_W(8)) dut_c (.clock(clock), .resetn(resetn), .bus_io(if_c));

  assign if_a.w = w_r;  assign if_a.en = en_r;  assign if_a.mode = mode_r;  assign if_a.clr = clr_r;
  assign if_b.w = w_r;  assign if_b.en = en_r;  assign if_b.mode = mode_r;  assign if_b.clr = clr_r;
  assign if_c.w = w_r;  assign if_c.en = en_r;  assign if_c.mode = mode_r;  assign if_c.clr = clr_r;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state, one entry per configuration.
  int unsigned m_rl  [3] = '{4, 4, 1};
  int unsigned m_max [3] = '{255, 3, 255};
  bit          m_valid [3];
  bit          m_prev  [3];
  bit          m_one   [3];
  bit          m_zero  [3];
  int unsigned m_cnt   [3];
  int unsigned m_ones  [3];
  int unsigned m_zeros [3];

  int unsigned exp_lvl_one [7] = '{0, 0, 0, 1, 1, 1, 0};
  int unsigned exp_pls_one [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int unsigned exp_pls_cur [8] = '{1, 2, 3, 4, 1, 2, 3, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit hit;
    bit hold;
    hit  = 1'b0;
    hold = 1'b0;
    if (!resetn) begin
      m_valid[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
      m_one[k] = 0; m_zero[k] = 0; m_ones[k] = 0; m_zeros[k] = 0;
    end else begin
      if (en_r) begin
        if (!m_valid[k] || (w_r != m_prev[k])) begin
          m_valid[k] = 1; m_prev[k] = w_r; m_cnt[k] = 1;
        end else if (m_cnt[k] < m_rl[k]) begin
          m_cnt[k]++;
        end else if (mode_r) begin
          m_cnt[k] = 1;
        end else begin
          hold = 1'b1;
        end
        hit = (m_cnt[k] == m_rl[k]) && !hold;
        if (!mode_r) begin
          m_one[k]  = (m_cnt[k] == m_rl[k]) && w_r;
          m_zero[k] = (m_cnt[k] == m_rl[k]) && !w_r;
        end else begin
          m_one[k]  = hit && w_r;
          m_zero[k] = hit && !w_r;
        end
      end else if (mode_r) begin
        m_one[k] = 0; m_zero[k] = 0;
      end
      if (clr_r) begin
        m_ones[k] = 0; m_zeros[k] = 0;
      end else if (hit) begin
        if (w_r && m_ones[k] < m_max[k]) m_ones[k]++;
        if (!w_r && m_zeros[k] < m_max[k]) m_zeros[k]++;
      end
    end
  endtask

  task automatic check_all();
    chk("a.one_yes",  32'(if_a.one_yes),      32'(m_one[0]));
    chk("a.zero_yes", 32'(if_a.zero_yes),     32'(m_zero[0]));
    chk("a.run_cur",  32'(if_a.run_cur),      m_cnt[0]);
    chk("a.ones",     32'(if_a.ones_events),  m_ones[0]);
    chk("a.zeros",    32'(if_a.zeros_events), m_zeros[0]);
    chk("b.one_yes",  32'(if_b.one_yes),      32'(m_one[1]));
    chk("b.zero_yes", 32'(if_b.zero_yes),     32'(m_zero[1]));
    chk("b.run_cur",  32'(if_b.run_cur),      m_cnt[1]);
    chk("b.ones",     32'(if_b.ones_events),  m_ones[1]);
    chk("b.zeros",    32'(if_b.zeros_events), m_zeros[1]);
    chk("c.one_yes",  32'(if_c.one_yes),      32'(m_one[2]));
    chk("c.zero_yes", 32'(if_c.zero_yes),     32'(m_zero[2]));
    chk("c.run_cur",  32'(if_c.run_cur),      m_cnt[2]);
    chk("c.ones",     32'(if_c.ones_events),  m_ones[2]);
    chk("c.zeros",    32'(if_c.zeros_events), m_zeros[2]);
    chk("a.excl", 32'(if_a.one_yes & if_a.zero_yes), 32'd0);
    chk("c.excl", 32'(if_c.one_yes & if_c.zero_yes), 32'd0);
  endtask

  task automatic step(input bit i_w, input bit i_en, input bit i_mode, input bit i_clr,
                      input bit i_rstn);
    @(negedge clock);
    w_r = i_w; en_r = i_en; mode_r = i_mode; clr_r = i_clr; resetn = i_rstn;
    @(posedge clock);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_all();
  endtask

  initial begin
    w_r = 0; en_r = 0; mode_r = 0; clr_r = 0; resetn = 0;

    // Reset state.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst.run_cur", 32'(if_a.run_cur), 32'd0);
    chk("rst.ones", 32'(if_a.ones_events), 32'd0);

    // Level mode: 1x6 then 0.
    for (int i = 0; i < 7; i++) begin
      step((i < 6) ? 1'b1 : 1'b0, 1, 0, 0, 1);
      chk("lvl.one_yes", 32'(if_a.one_yes), exp_lvl_one[i]);
    end
    chk("lvl.ones_events", 32'(if_a.ones_events), 32'd1);

    // Pulse mode: eight 1s.
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0, 1);
      chk("pls.one_yes", 32'(if_a.one_yes), exp_pls_one[i]);
      chk("pls.run_cur", 32'(if_a.run_cur), exp_pls_cur[i]);
    end
    chk("pls.ones_events", 32'(if_a.ones_events), 32'd2);

    // Enable gating.
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("gate.zero_early", 32'(if_a.zero_yes), 32'd0);
    step(0, 1, 0, 0, 1);
    chk("gate.zero_yes", 32'(if_a.zero_yes), 32'd1);
    chk("gate.zeros_events", 32'(if_a.zeros_events), 32'd1);

    // Reset mid-run.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    chk("mid.one_yes", 32'(if_a.one_yes), 32'd0);
    chk("mid.run_cur", 32'(if_a.run_cur), 32'd0);
    chk("mid.ones", 32'(if_a.ones_events), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 1);
      chk("mid.hit", 32'(if_a.one_yes), (i == 3) ? 32'd1 : 32'd0);
    end

    // Saturation on the 2-bit counter, then clear coincident with a hit.
    step(0, 0, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      step(1, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    end
    chk("sat.zeros_b", 32'(if_b.zeros_events), 32'd3);
    chk("sat.zeros_a", 32'(if_a.zeros_events), 32'd5);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    chk("clr.zeros_b", 32'(if_b.zeros_events), 32'd0);
    chk("clr.zeros_a", 32'(if_a.zeros_events), 32'd0);

    // RUN_LEN=1 pulse mode: 1,0,1.
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    chk("r1.one0", 32'(if_c.one_yes), 32'd1);
    chk("r1.zero0", 32'(if_c.zero_yes), 32'd0);
    step(0, 1, 1, 0, 1);
    chk("r1.one1", 32'(if_c.one_yes), 32'd0);
    chk("r1.zero1", 32'(if_c.zero_yes), 32'd1);
    step(1, 1, 1, 0, 1);
    chk("r1.one2", 32'(if_c.one_yes), 32'd1);
    chk("r1.zero2", 32'(if_c.zero_yes), 32'd0);
    chk("r1.ones", 32'(if_c.ones_events), 32'd2);

    // Randomized phase against the model.
    begin
      bit md;
      md = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) md = ~md;
        step(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0),
             md,
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 149) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised run-length detector on a single serial input bit. It generalises the fixed four-sample ones/zeros detector in three ways: the run length is a parameter, sampling is gated by an enable, and it offers both a level mode and a non-overlapping pulse mode. It also keeps saturating per-polarity event counters. It sits between the debounced switch/key front end and the LEDG/HEX display logic of the lab board top level.

## Interface
- `RUN_LEN`, default 4: number of consecutive equal samples that constitutes a hit; legal range 1..255.
- `CNT_W`, default 8: width of each event counter.
- `clock` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: reset is synchronous and active-low.
- `w` in 1: serial data bit.
- `en` in 1: sample enable; `w` is consumed only on edges where `en`=1.
- `mode` in 1: 0 = level mode, 1 = pulse (non-overlapping) mode.
- `clr` in 1: synchronous clear of both event counters only.
- `one_yes` out 1: ones-run hit indication.
- `zero_yes` out 1: zeros-run hit indication.
- `run_cur` out clog2(RUN_LEN+1): current run length.
- `ones_events` out CNT_W: number of ones hits, saturating.
- `zeros_events` out CNT_W: number of zeros hits, saturating.

## Operation
- Internal state:
  - `valid`: at least one sample taken since reset.
  - `prev`: last sampled bit.
  - `cnt`: run length.
  - `one_yes`, `zero_yes`: registered hit flags.
  - Event counters.
- Reset (`resetn`=0 at an edge): `valid`=0, `prev`=0, `cnt`=0, `one_yes`=0, `zero_yes`=0, both event counters 0. Reset wins over `en`, `clr` and all other inputs. Reset mid-run discards any partial run.
- Sample edge (`en`=1):
  - If `valid`=0 or `w`≠`prev`: `cnt`←1, `prev`←`w`, `valid`←1.
  - Else if `cnt`<RUN_LEN: `cnt`←`cnt`+1.
  - Else (`cnt`=RUN_LEN): level mode holds `cnt` at RUN_LEN; pulse mode restarts `cnt`←1.
  - Hit: this sample makes the updated `cnt` equal RUN_LEN, and the previous state was not already a saturated level-mode run of the same bit.
- Level mode: `one_yes`←(updated `cnt`=RUN_LEN && `w`=1); `zero_yes` is the same with `w`=0. Both stay asserted while the run continues and clear on the first opposite sample.
- Pulse mode: the flag for the hit polarity is 1 for exactly one cycle after the hit edge, then 0 on the next edge regardless of `en`.
- Non-sample edge (`en`=0): run state holds. Level-mode flags hold. Pulse-mode flags clear.
- Event counters: increment the matching polarity once per hit; saturate at 2^CNT_W−1 with no wrap. `clr`=1 forces both counters to 0, and a simultaneous hit is dropped (clear wins).
- `mode` is sampled every edge. Changing it does not reset run state or counters. A run already saturated in level mode that continues after a switch to pulse mode restarts at 1 on its next equal sample.
- RUN_LEN=1: every sample is a hit. Level mode gives an event per bit change. Pulse mode gives a pulse and an event on every sample.
- `one_yes` and `zero_yes` are never both 1.

## Timing
- Latency: flag and counter update are visible one cycle after the rising edge that samples the completing bit, i.e. registered outputs with no combinational path from `w`.
- `run_cur` mirrors `cnt` (registered).
- The throughput is one sample per clock.

## Structure
- Shared package/header `run_det_pkg` holds:
  - `MODE_LEVEL`=1'b0 and `MODE_PULSE`=1'b1 constants.
  - A `clog2`-based width function for `run_cur`.
- One sub-module `sat_counter` (params WIDTH; inputs `clock`, `resetn`, `clr`, `inc`; output `q`), instantiated twice for the ones and zeros event counters.

## Test plan
- Level mode, RUN_LEN=4, `en`=1:
  - Stimulus: `w`=1,1,1,1,1,1,0.
  - `one_yes` is 0 for the first 3 samples and 1 after the 4th through the 6th.
  - 0 after the 0 sample; `ones_events`=1.
- Pulse mode, RUN_LEN=4:
  - Stimulus: eight 1s.
  - `one_yes` pulses one cycle after the 4th and after the 8th sample.
  - `ones_events`=2; `run_cur` sequence is 1,2,3,4,1,2,3,4.
- Enable gating:
  - Stimulus: 0,0, then `en`=0 for 5 cycles with `w`=1, then 0,0.
  - `zero_yes` rises after the 4th enabled 0; `zeros_events`=1.
- Reset mid-run:
  - Stimulus: three 1s, `resetn`=0 for one edge, then four 1s.
  - No hit before the 4th post-reset 1; all outputs are 0 in the cycle after reset.
- Saturation and clear (CNT_W=2):
  - Five separate zero runs give `zeros_events`=3.
  - `clr` coincident with a hit gives 0.
- Edge case, RUN_LEN=1, pulse mode:
  - Stimulus: 1,0,1.
  - Three single-cycle pulses alternating `one_yes`/`zero_yes`.
  - Both flags never 1 together.
